// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between NREQ requesters, the arbiter and a registered-read memory.
// Handshake: requester i holds req_valid/req_we/req_addr/req_wdata stable
// while req_valid=1 and req_ready=0; the operation is accepted on the rising
// clock edge where req_valid[i] & req_ready[i] are both 1. Read data comes
// back exactly one cycle after acceptance, flagged by rsp_valid, and cannot
// be stalled.
interface mem_port_arbiter_if #(
  parameter int NREQ   = 2,
  parameter int AWIDTH = 16,
  parameter int DWIDTH = 16
) ();

  // Requester side
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_we;
  logic [NREQ*AWIDTH-1:0] req_addr;
  logic [NREQ*DWIDTH-1:0] req_wdata;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        rsp_valid;
  logic [DWIDTH-1:0]      rsp_data;

  // Memory side
  logic                   mem_re;
  logic [AWIDTH-1:0]      mem_raddr;
  logic [DWIDTH-1:0]      mem_rdata;
  logic                   mem_we;
  logic [AWIDTH-1:0]      mem_waddr;
  logic [DWIDTH-1:0]      mem_wdata;

  // Requesters plus memory model: drive requests and read data.
  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_data,
    input  mem_re, mem_raddr, mem_we, mem_waddr, mem_wdata
  );

  // Arbiter: grants requests and drives the memory ports.
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_data,
    output mem_re, mem_raddr, mem_we, mem_waddr, mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory with separate read and write ports among NREQ requesters.
// Reads and writes are arbitrated independently with round-robin pointers, so
// one read and one write can issue per cycle. Read responses return one cycle
// after acceptance, tagged one-hot with the requester that issued them.
// rd_ptr_o/wr_ptr_o expose the arbitration pointers for observation.
module mem_port_arbiter #(
  parameter int  NREQ      = 2,
  parameter int  AWIDTH    = 16,
  parameter int  DWIDTH    = 16,
  parameter bit  RAW_STALL = 1'b1,
  localparam int PW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  mem_port_arbiter_if.slave      bus,
  output logic [PW-1:0]          rd_ptr_o,
  output logic [PW-1:0]          wr_ptr_o
);

  localparam logic [PW:0]   NREQ_W = (PW+1)'(NREQ);
  localparam logic [PW-1:0] LAST   = PW'(NREQ - 1);

  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;

  logic [AWIDTH-1:0] addr_a  [NREQ];
  logic [DWIDTH-1:0] wdata_a [NREQ];

  logic [NREQ-1:0]   rd_c, wr_c, raw_hit, rd_elig;
  logic [NREQ-1:0]   rd_oh, wr_oh;
  logic              rd_gnt, wr_gnt;
  logic [PW-1:0]     rd_win, wr_win;

  // Round-robin search: first set bit of cand at or above ptr, wrapping at
  // NREQ. Returns {found, index}.
  function automatic logic [PW:0] rr_pick(input logic [NREQ-1:0] cand,
                                          input logic [PW-1:0]   ptr);
    logic          found;
    logic [PW-1:0] idx;
    logic [PW:0]   pos;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = {1'b0, ptr} + (PW+1)'(k);
      if (pos >= NREQ_W) pos = pos - NREQ_W;
      if (!found && cand[pos[PW-1:0]]) begin
        found = 1'b1;
        idx   = pos[PW-1:0];
      end
    end
    return {found, idx};
  endfunction

  // Pointer moves one past the winner, wrapping NREQ-1 -> 0.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] idx);
    return (idx == LAST) ? '0 : idx + PW'(1);
  endfunction

  // Unpack the flat address/data buses into per-requester slices.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      addr_a[i]  = bus.req_addr[i*AWIDTH +: AWIDTH];
      wdata_a[i] = bus.req_wdata[i*DWIDTH +: DWIDTH];
    end
  end

  // Arbitration: write winner first, so a same-address reader can be held
  // back one cycle and observe the newly written data.
  always_comb begin
    rd_c    = '0;
    wr_c    = '0;
    raw_hit = '0;
    rd_oh   = '0;
    wr_oh   = '0;
    // Gating candidates with reset forces every grant and enable low.
    if (rst_ni) begin
      rd_c = bus.req_valid & ~bus.req_we;
      wr_c = bus.req_valid &  bus.req_we;
    end
    {wr_gnt, wr_win} = rr_pick(wr_c, wr_ptr_q);
    for (int i = 0; i < NREQ; i++) begin
      raw_hit[i] = RAW_STALL && wr_gnt && (addr_a[i] == addr_a[wr_win]);
    end
    rd_elig = rd_c & ~raw_hit;
    {rd_gnt, rd_win} = rr_pick(rd_elig, rd_ptr_q);
    if (wr_gnt) wr_oh[wr_win] = 1'b1;
    if (rd_gnt) rd_oh[rd_win] = 1'b1;
  end

  // Grants and memory drive; idle address/data outputs are held at zero.
  always_comb begin
    bus.req_ready = wr_oh | rd_oh;
    bus.mem_we    = wr_gnt;
    bus.mem_waddr = wr_gnt ? addr_a[wr_win]  : '0;
    bus.mem_wdata = wr_gnt ? wdata_a[wr_win] : '0;
    bus.mem_re    = rd_gnt;
    bus.mem_raddr = rd_gnt ? addr_a[rd_win]  : '0;
  end

  // Next-state: pointers advance only on a grant in their own class; the
  // response flag tracks this cycle's read grant.
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    rsp_valid_d = rd_oh;
    if (rd_gnt) rd_ptr_d = next_ptr(rd_win);
    if (wr_gnt) wr_ptr_d = next_ptr(wr_win);
  end

  // State registers; reset drops any response still in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      rsp_valid_q <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Read data comes straight from the memory's output register.
  always_comb begin
    bus.rsp_valid = rsp_valid_q;
    bus.rsp_data  = bus.mem_rdata;
    rd_ptr_o      = rd_ptr_q;
    wr_ptr_o      = wr_ptr_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (same-address read stall on and
// off), each with a registered-read memory model. Expected read responses
// are queued by the stimulus and popped by per-instance response monitors.
module tb_mem_port_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int W    = NREQ + DW;

  logic clk;
  logic rst_n;
  logic rd_ptr_a, wr_ptr_a, rd_ptr_b, wr_ptr_b;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_a_q[$];
  logic [W-1:0] exp_b_q[$];
  logic [W-1:0] e_a, e_b;

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.NREQ(NREQ), .AWIDTH(AW), .DWIDTH(DW)) ifa ();
  mem_port_arbiter_if #(.NREQ(NREQ), .AWIDTH(AW), .DWIDTH(DW)) ifb ();

  mem_port_arbiter #(.NREQ(NREQ), .AWIDTH(AW), .DWIDTH(DW), .RAW_STALL(1'b1)) dut_a (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .bus     (ifa),
    .rd_ptr_o(rd_ptr_a),
    .wr_ptr_o(wr_ptr_a)
  );

  mem_port_arbiter #(.NREQ(NREQ), .AWIDTH(AW), .DWIDTH(DW), .RAW_STALL(1'b0)) dut_b (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .bus     (ifb),
    .rd_ptr_o(rd_ptr_b),
    .wr_ptr_o(wr_ptr_b)
  );

  // Memory contents after reset: 0x10 holds 0xBEEF, any other addr a holds 0xC0aa.
  function automatic logic [DW-1:0] init_val(input logic [7:0] a);
    return (a == 8'h10) ? 16'hBEEF : {8'hC0, a};
  endfunction

  logic [DW-1:0] mem_a [256];
  logic [DW-1:0] mem_b [256];
  logic [DW-1:0] rdata_a, rdata_b;

  // Memory models: registered read, read-before-write on the same edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) begin
        mem_a[i] <= init_val(8'(i));
        mem_b[i] <= init_val(8'(i));
      end
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      if (ifa.mem_re) rdata_a <= mem_a[ifa.mem_raddr[7:0]];
      if (ifa.mem_we) mem_a[ifa.mem_waddr[7:0]] <= ifa.mem_wdata;
      if (ifb.mem_re) rdata_b <= mem_b[ifb.mem_raddr[7:0]];
      if (ifb.mem_we) mem_b[ifb.mem_waddr[7:0]] <= ifb.mem_wdata;
    end
  end

  assign ifa.mem_rdata = rdata_a;
  assign ifb.mem_rdata = rdata_b;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Driver tasks
  task automatic drive_a(input int i, input logic v, input logic we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    ifa.req_valid[i]          = v;
    ifa.req_we[i]             = we;
    ifa.req_addr[i*AW +: AW]  = addr;
    ifa.req_wdata[i*DW +: DW] = wd;
  endtask

  task automatic drive_b(input int i, input logic v, input logic we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    ifb.req_valid[i]          = v;
    ifb.req_we[i]             = we;
    ifb.req_addr[i*AW +: AW]  = addr;
    ifb.req_wdata[i*DW +: DW] = wd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitors: every response must match the head of its queue.
  always @(negedge clk) begin
    if (ifa.rsp_valid != '0) begin
      if (exp_a_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_a_unexpected: got valid=%b data=%h expected none",
                 ifa.rsp_valid, ifa.rsp_data);
      end else begin
        e_a = exp_a_q.pop_front();
        check("rsp_a_valid", 32'(ifa.rsp_valid), 32'(e_a[W-1:DW]));
        check("rsp_a_data",  32'(ifa.rsp_data),  32'(e_a[DW-1:0]));
      end
    end
  end

  always @(negedge clk) begin
    if (ifb.rsp_valid != '0) begin
      if (exp_b_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_b_unexpected: got valid=%b data=%h expected none",
                 ifb.rsp_valid, ifb.rsp_data);
      end else begin
        e_b = exp_b_q.pop_front();
        check("rsp_b_valid", 32'(ifb.rsp_valid), 32'(e_b[W-1:DW]));
        check("rsp_b_data",  32'(ifb.rsp_data),  32'(e_b[DW-1:0]));
      end
    end
  end

  initial begin
    rst_n         = 1'b0;
    ifa.req_valid = '0; ifa.req_we = '0; ifa.req_addr = '0; ifa.req_wdata = '0;
    ifb.req_valid = '0; ifb.req_we = '0; ifb.req_addr = '0; ifb.req_wdata = '0;

    // Reset with both requesters valid: nothing may be granted.
    drive_a(0, 1'b1, 1'b0, 16'h0010, 16'h0000);
    drive_a(1, 1'b1, 1'b0, 16'h0030, 16'h0000);
    @(negedge clk);
    check("rst_ready",     32'(ifa.req_ready), 32'h0);
    check("rst_mem_re",    32'(ifa.mem_re),    32'h0);
    check("rst_mem_we",    32'(ifa.mem_we),    32'h0);
    check("rst_rsp_valid", 32'(ifa.rsp_valid), 32'h0);
    check("rst_rd_ptr",    32'(rd_ptr_a),      32'h0);
    check("rst_wr_ptr",    32'(wr_ptr_a),      32'h0);

    // Release: grants start at 0, then alternate while both keep reading.
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) begin
        check($sformatf("rr_ready%0d", k), 32'(ifa.req_ready), 32'h1);
        exp_a_q.push_back({2'b01, 16'hBEEF});
      end else begin
        check($sformatf("rr_ready%0d", k), 32'(ifa.req_ready), 32'h2);
        exp_a_q.push_back({2'b10, 16'hC030});
      end
      step();
    end
    drive_a(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    drive_a(1, 1'b0, 1'b0, 16'h0000, 16'h0000);

    // Single read of 0x10 by requester 0.
    drive_a(0, 1'b1, 1'b0, 16'h0010, 16'h0000);
    #1;
    check("single_ready",     32'(ifa.req_ready), 32'h1);
    check("single_mem_re",    32'(ifa.mem_re),    32'h1);
    check("single_mem_raddr", 32'(ifa.mem_raddr), 32'h10);
    exp_a_q.push_back({2'b01, 16'hBEEF});
    step();
    drive_a(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    check("single_rsp_valid", 32'(ifa.rsp_valid), 32'h1);
    check("single_rsp_data",  32'(ifa.rsp_data),  32'hBEEF);

    // Parallel write 0x20<-0x1234 and read 0x30, then read back 0x20.
    drive_a(0, 1'b1, 1'b1, 16'h0020, 16'h1234);
    drive_a(1, 1'b1, 1'b0, 16'h0030, 16'h0000);
    #1;
    check("par_ready",     32'(ifa.req_ready), 32'h3);
    check("par_mem_we",    32'(ifa.mem_we),    32'h1);
    check("par_mem_waddr", 32'(ifa.mem_waddr), 32'h20);
    check("par_mem_wdata", 32'(ifa.mem_wdata), 32'h1234);
    check("par_mem_re",    32'(ifa.mem_re),    32'h1);
    check("par_mem_raddr", 32'(ifa.mem_raddr), 32'h30);
    exp_a_q.push_back({2'b10, 16'hC030});
    step();
    drive_a(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    drive_a(1, 1'b1, 1'b0, 16'h0020, 16'h0000);
    #1;
    check("rb_ready", 32'(ifa.req_ready), 32'h2);
    exp_a_q.push_back({2'b10, 16'h1234});
    step();
    drive_a(1, 1'b0, 1'b0, 16'h0000, 16'h0000);

    // Same-address write 0x40<-0xAAAA and read on both instances.
    drive_a(0, 1'b1, 1'b1, 16'h0040, 16'hAAAA);
    drive_a(1, 1'b1, 1'b0, 16'h0040, 16'h0000);
    drive_b(0, 1'b1, 1'b1, 16'h0040, 16'hAAAA);
    drive_b(1, 1'b1, 1'b0, 16'h0040, 16'h0000);
    #1;
    check("raw1_ready",  32'(ifa.req_ready), 32'h1);
    check("raw1_mem_re", 32'(ifa.mem_re),    32'h0);
    check("raw0_ready",  32'(ifb.req_ready), 32'h3);
    exp_b_q.push_back({2'b10, 16'hC040});
    step();
    drive_a(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    drive_b(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    drive_b(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    #1;
    check("raw1_retry_ready", 32'(ifa.req_ready), 32'h2);
    check("raw1_retry_raddr", 32'(ifa.mem_raddr), 32'h40);
    exp_a_q.push_back({2'b10, 16'hAAAA});
    step();
    drive_a(1, 1'b0, 1'b0, 16'h0000, 16'h0000);

    // Reset while a read response is on the bus: it must vanish at once.
    drive_a(0, 1'b1, 1'b0, 16'h0010, 16'h0000);
    #1;
    check("mid_ready", 32'(ifa.req_ready), 32'h1);
    step();
    drive_a(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    check("mid_rsp_before", 32'(ifa.rsp_valid), 32'h1);
    check("mid_rd_ptr_pre", 32'(rd_ptr_a),      32'h1);
    check("mid_wr_ptr_pre", 32'(wr_ptr_a),      32'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rsp_after",  32'(ifa.rsp_valid), 32'h0);
    check("mid_rd_ptr",     32'(rd_ptr_a),      32'h0);
    check("mid_wr_ptr",     32'(wr_ptr_a),      32'h0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (3) step();

    check("exp_a_empty", 32'(exp_a_q.size()), 32'h0);
    check("exp_b_empty", 32'(exp_b_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
